// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin using one full-subtractor cell and a registered borrow,
// LSB first, with valid/ready handshakes on operands and result.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb;
  logic [IW-1:0] idx;
  logic br, d, br_n, last;
  assign d = sa[0] ^ sb[0] ^ br;
  assign br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last = idx == IW'(WIDTH - 1);
  assign bout = br;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    if (in_ready && in_valid) state_n = RUN;
    else if (state == RUN && last) state_n = DONE;
    else if (out_valid && out_ready) state_n = IDLE;
  end
  // on the final bit sa[0]/sb[0] are the operand sign bits and d is the result sign bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      br <= 1'b0;
      idx <= '0;
      diff <= '0;
      ovf <= 1'b0;
    end else if (in_ready && in_valid) begin
      sa <= a;
      sb <= b;
      br <= bin;
      idx <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      br <= br_n;
      idx <= idx + IW'(1);
      diff <= {d, diff[WIDTH-1:1]};
      if (last) ovf <= (sa[0] ^ sb[0]) & (d ^ sa[0]);
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor at WIDTH=4 and WIDTH=8
// against an integer-arithmetic reference model.
module tb_serial_subtractor;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic iv4 = 0, ir4, ov4, or4 = 0, bin4 = 0, bout4, ovf4;
  logic [3:0] a4 = 0, b4 = 0, d4;
  logic iv8 = 0, ir8, ov8, or8 = 0, bin8 = 0, bout8, ovf8;
  logic [7:0] a8 = 0, b8 = 0, d8;
  int total = 0, bad = 0;

  serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .bin(bin4), .out_valid(ov4), .out_ready(or4), .diff(d4), .bout(bout4), .ovf(ovf4));
  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bout8), .ovf(ovf8));

  // {ovf, bout, diff[31:0]} from plain unsigned and signed integer arithmetic
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input logic bi);
    longint m, ua, ub, sa, sb, u, s;
    logic [31:0] dd;
    m = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[w-1] ? ua - m : ua;
    sb = b[w-1] ? ub - m : ub;
    u = ua - ub - longint'(bi);
    s = sa - sb - longint'(bi);
    dd = 32'(u < 0 ? u + m : u);
    return {(s < -(m / 2)) || (s >= m / 2), u < 0, dd};
  endfunction

  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic bi,
                        input bit early, input int stall, output logic [33:0] res, output int lat);
    int n = 0;
    while (!(w == 4 ? ir4 : ir8) && n < 50) begin @(posedge clk); #1; n++; end
    if (w == 4) begin a4 = a[3:0]; b4 = b[3:0]; bin4 = bi; iv4 = 1; or4 = early; end
    else begin a8 = a[7:0]; b8 = b[7:0]; bin8 = bi; iv8 = 1; or8 = early; end
    @(posedge clk); #1;
    iv4 = 0; iv8 = 0; lat = 0;
    while (!(w == 4 ? ov4 : ov8) && lat < 50) begin @(posedge clk); #1; lat++; end
    res = w == 4 ? {ovf4, bout4, 28'd0, d4} : {ovf8, bout8, 24'd0, d8};
    if (!early) repeat (stall) begin @(posedge clk); #1; end
    or4 = 1; or8 = 1;
    @(posedge clk); #1;
    or4 = 0; or8 = 0;
  endtask

  task automatic test_reset;
    repeat (3) begin @(posedge clk); #1; end
    total++; if ({ir4, ov4, d4, bout4, ovf4} !== 8'b1_0_0000_0_0) begin bad++;
      $display("FAIL reset4: ir=%0b ov=%0b d=%0d bo=%0b ovf=%0b want 1 0 0 0 0", ir4, ov4, d4, bout4, ovf4); end
    total++; if ({ir8, ov8, d8, bout8, ovf8} !== 12'b1_0_00000000_0_0) begin bad++;
      $display("FAIL reset8: ir=%0b ov=%0b d=%0d bo=%0b ovf=%0b want 1 0 0 0 0", ir8, ov8, d8, bout8, ovf8); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [3:0] ta[5] = '{4'd5, 4'd3, 4'd0, 4'd8, 4'd7};
    logic [3:0] tb[5] = '{4'd3, 4'd5, 4'd0, 4'd1, 4'd15};
    logic tbi[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [5:0] want[5] = '{6'b00_0010, 6'b01_1110, 6'b01_1111, 6'b10_0111, 6'b11_1000};
    logic [33:0] r;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(4, 32'(ta[i]), 32'(tb[i]), tbi[i], i[0], 2, r, lat);
      total++; if ({r[33:32], r[3:0]} !== want[i]) begin bad++;
        $display("FAIL dir%0d: got ovf,bo,d=%b want %b", i, {r[33:32], r[3:0]}, want[i]); end
      total++; if (lat !== 4) begin bad++; $display("FAIL latency%0d: got %0d want 4", i, lat); end
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    a4 = 6; b4 = 2; bin4 = 0; iv4 = 1;
    @(posedge clk); #1;
    iv4 = 0;
    while (!ov4 && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom); iv4 = 1'(i);
      @(posedge clk); #1;
      total++; if ({ov4, ir4, ovf4, bout4, d4} !== 8'b1_0_0_0_0100) begin bad++;
        $display("FAIL hold%0d: ov=%0b ir=%0b ovf=%0b bo=%0b d=%0d want 1 0 0 0 4", i, ov4, ir4, ovf4, bout4, d4); end
    end
    iv4 = 0; or4 = 1;
    @(posedge clk); #1;
    or4 = 0;
    total++; if ({ov4, ir4} !== 2'b01) begin bad++;
      $display("FAIL release: ov=%0b ir=%0b want 0 1", ov4, ir4); end
    repeat (3) begin @(posedge clk); #1; end
    total++; if ({ov4, ir4, d4} !== 6'b01_0100) begin bad++;
      $display("FAIL single_xfer: ov=%0b ir=%0b d=%0d want 0 1 4", ov4, ir4, d4); end
  endtask

  task automatic test_reset_mid;
    logic [33:0] r;
    int lat, seen = 0;
    a4 = 5; b4 = 1; bin4 = 0; iv4 = 1;
    @(posedge clk); #1;
    iv4 = 0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 0;
    #1;
    total++; if ({ir4, ov4, d4, bout4, ovf4} !== 8'b1_0_0000_0_0) begin bad++;
      $display("FAIL async_reset: ir=%0b ov=%0b d=%0d bo=%0b ovf=%0b want 1 0 0 0 0", ir4, ov4, d4, bout4, ovf4); end
    @(posedge clk); #1;
    rst_n = 1;
    repeat (8) begin @(posedge clk); #1; seen += int'(ov4); end
    total++; if (seen !== 0) begin bad++; $display("FAIL aborted: out_valid cycles=%0d want 0", seen); end
    run_op(4, 32'd9, 32'd4, 1'b0, 1'b0, 1, r, lat);
    total++; if (r[3:0] !== 4'd5 || r !== model(4, 32'd9, 32'd4, 1'b0)) begin bad++;
      $display("FAIL after_reset: got %h want %h", r, model(4, 32'd9, 32'd4, 1'b0)); end
  endtask

  task automatic test_exhaustive4;
    logic [33:0] r, m;
    int lat;
    for (int v = 0; v < 512; v++) begin
      run_op(4, 32'(v[7:4]), 32'(v[3:0]), v[8], 1'($urandom), int'($urandom_range(0, 3)), r, lat);
      m = model(4, 32'(v[7:4]), 32'(v[3:0]), v[8]);
      total++; if (r !== m) begin bad++;
        $display("FAIL exh4 a=%0d b=%0d bin=%0b: got %h want %h", v[7:4], v[3:0], v[8], r, m); end
    end
  endtask

  task automatic test_random8;
    logic [33:0] r, m;
    logic [31:0] a, b;
    logic bi;
    int lat;
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255); bi = 1'($urandom);
      run_op(8, a, b, bi, 1'($urandom), int'($urandom_range(0, 3)), r, lat);
      m = model(8, a, b, bi);
      total++; if (r !== m || lat !== 8) begin bad++;
        $display("FAIL rnd8 a=%0d b=%0d bin=%0b: got %h lat=%0d want %h lat=8", a, b, bi, r, lat, m); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_exhaustive4;
    test_random8;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
